// File: rtl/delay_pkg.sv
// Shared types, default parameters and the saturation helper for the stereo delay core.
package delay_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 14;
  localparam int GAIN_W_DEF = 8;

  typedef enum logic {
    DUAL     = 1'b0,
    PINGPONG = 1'b1
  } delay_mode_e;

  // Clamp a 32-bit signed value to the w-bit signed range; callers keep the low w bits.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/delay_fb_core_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no reset.
module delay_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/delay_fb_core.sv
// Stereo delay with feedback, wet mix and ping-pong; fixed 2-cycle valid_in -> valid_out.
// No backpressure: valid_in strobes must be at least 3 cycles apart.
module delay_fb_core
  import delay_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  input  logic        [ADDR_W-1:0] delay_len,
  input  logic        [GAIN_W-1:0] fb_gain,
  input  logic        [GAIN_W-1:0] mix,
  input  logic                     mode,
  input  logic                     bypass,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out
);

  localparam int PW = DATA_W + GAIN_W + 1;

  function automatic logic signed [PW-1:0] gain(input logic signed [DATA_W-1:0] x,
                                                input logic        [GAIN_W-1:0] k);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ke;
    logic signed [PW-1:0] p;
    xe = {{(GAIN_W + 1){x[DATA_W-1]}}, x};
    ke = {{(DATA_W + 1){1'b0}}, k};
    p  = xe * ke;
    return p >>> GAIN_W;
  endfunction

  logic [ADDR_W-1:0] wp_q, wp_d, fill_q, fill_d, dly_eff, rd_addr;
  logic              tap_ok;

  logic                     v1_q, v1_d, v2_q, v2_d;
  logic signed [DATA_W-1:0] l1_q, l1_d, r1_q, r1_d;
  logic        [GAIN_W-1:0] fb1_q, fb1_d, mix1_q, mix1_d;
  delay_mode_e              mode1_q, mode1_d;
  logic                     byp1_q, byp1_d, tok1_q, tok1_d;

  logic signed [DATA_W-1:0] lo_q, lo_d, ro_q, ro_d;
  logic signed [DATA_W-1:0] wl_q, wl_d, wr_q, wr_d;
  logic        [DATA_W-1:0] ram_l_rd, ram_r_rd;

  logic signed [DATA_W-1:0] tap_l, tap_r;
  logic signed [31:0]       mono, wl_s, wr_s, ol_s, or_s;

  // Stage 0: read address and warm-up gate use the delay_len seen on the strobe.
  always_comb begin
    dly_eff = (delay_len == '0) ? ADDR_W'(1) : delay_len;
    rd_addr = wp_q - dly_eff;
    tap_ok  = (fill_q >= dly_eff);
    v1_d    = valid_in;
    l1_d    = valid_in ? left_in  : l1_q;
    r1_d    = valid_in ? right_in : r1_q;
    fb1_d   = valid_in ? fb_gain  : fb1_q;
    mix1_d  = valid_in ? mix      : mix1_q;
    mode1_d = valid_in ? delay_mode_e'(mode) : mode1_q;
    byp1_d  = valid_in ? bypass   : byp1_q;
    tok1_d  = valid_in ? tap_ok   : tok1_q;
  end

  // Stage 1: RAM data is back; all arithmetic done at 32 bits then clamped.
  always_comb begin
    tap_l = tok1_q ? $signed(ram_l_rd) : '0;
    tap_r = tok1_q ? $signed(ram_r_rd) : '0;
    mono  = (32'(l1_q) + 32'(r1_q)) >>> 1;
    if (mode1_q == PINGPONG) begin
      wl_s = sat(mono + 32'(gain(tap_r, fb1_q)), DATA_W);
      wr_s = sat(32'(gain(tap_l, fb1_q)), DATA_W);
    end else begin
      wl_s = sat(32'(l1_q) + 32'(gain(tap_l, fb1_q)), DATA_W);
      wr_s = sat(32'(r1_q) + 32'(gain(tap_r, fb1_q)), DATA_W);
    end
    ol_s = sat(32'(l1_q) + 32'(gain(tap_l, mix1_q)), DATA_W);
    or_s = sat(32'(r1_q) + 32'(gain(tap_r, mix1_q)), DATA_W);

    v2_d = v1_q;
    lo_d = lo_q;
    ro_d = ro_q;
    wl_d = wl_q;
    wr_d = wr_q;
    if (v1_q) begin
      lo_d = byp1_q ? l1_q : ol_s[DATA_W-1:0];
      ro_d = byp1_q ? r1_q : or_s[DATA_W-1:0];
      wl_d = wl_s[DATA_W-1:0];
      wr_d = wr_s[DATA_W-1:0];
    end
  end

  // Stage 2: buffer write commits at the end of this cycle together with wp/fill.
  always_comb begin
    wp_d   = v2_q ? wp_q + ADDR_W'(1) : wp_q;
    fill_d = (v2_q && fill_q != '1) ? fill_q + ADDR_W'(1) : fill_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      lo_q   <= '0;
      ro_q   <= '0;
      wp_q   <= '0;
      fill_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      lo_q   <= lo_d;
      ro_q   <= ro_d;
      wp_q   <= wp_d;
      fill_q <= fill_d;
    end
    l1_q    <= l1_d;
    r1_q    <= r1_d;
    fb1_q   <= fb1_d;
    mix1_q  <= mix1_d;
    mode1_q <= mode1_d;
    byp1_q  <= byp1_d;
    tok1_q  <= tok1_d;
    wl_q    <= wl_d;
    wr_q    <= wr_d;
  end

  delay_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_l (
    .clk(clk), .we(v2_q), .waddr(wp_q), .wdata(wl_q),
    .re(valid_in), .raddr(rd_addr), .rdata(ram_l_rd)
  );

  delay_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_r (
    .clk(clk), .we(v2_q), .waddr(wp_q), .wdata(wr_q),
    .re(valid_in), .raddr(rd_addr), .rdata(ram_r_rd)
  );

  assign valid_out = v2_q;
  assign left_out  = lo_q;
  assign right_out = ro_q;

endmodule

// File: tb/tb_delay_fb_core.sv
// Directed and random frames against a history-queue model of the delay; small ADDR_W to exercise wrap.
module tb_delay_fb_core;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int GW    = 8;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst, valid_in, mode, bypass;
  logic signed [DW-1:0] left_in, right_in;
  logic        [AW-1:0] delay_len;
  logic        [GW-1:0] fb_gain, mix;
  logic                 valid_out;
  logic signed [DW-1:0] left_out, right_out;

  delay_fb_core #(.DATA_W(DW), .ADDR_W(AW), .GAIN_W(GW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .left_in(left_in), .right_in(right_in), .delay_len(delay_len),
    .fb_gain(fb_gain), .mix(mix), .mode(mode), .bypass(bypass),
    .valid_out(valid_out), .left_out(left_out), .right_out(right_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int hl[$];
  int hr[$];

  function automatic int gm(int x, int k);
    return (x * k) >>> GW;
  endfunction

  function automatic int clamp(int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    left_in   = DW'($urandom);
    right_in  = DW'($urandom);
    delay_len = AW'($urandom);
    fb_gain   = GW'($urandom);
    mix       = GW'($urandom);
    mode      = 1'($urandom);
    bypass    = 1'($urandom);
  endtask

  // Called at a negedge; drives one frame, checks it, returns at the negedge 3 cycles later.
  task automatic frame(input int l, input int r, input int dl, input int fb, input int mx,
                       input int md, input int bp);
    int d, tl, tr, ol, orr, wl, wr, mono;
    d  = (dl == 0) ? 1 : dl;
    tl = (hl.size() >= d) ? hl[hl.size() - d] : 0;
    tr = (hr.size() >= d) ? hr[hr.size() - d] : 0;
    ol  = bp ? l : clamp(l + gm(tl, mx));
    orr = bp ? r : clamp(r + gm(tr, mx));
    if (md == 0) begin
      wl = clamp(l + gm(tl, fb));
      wr = clamp(r + gm(tr, fb));
    end else begin
      mono = (l + r) >>> 1;
      wl = clamp(mono + gm(tr, fb));
      wr = clamp(gm(tl, fb));
    end
    hl.push_back(wl);
    hr.push_back(wr);
    if (hl.size() > DEPTH) begin
      void'(hl.pop_front());
      void'(hr.pop_front());
    end

    left_in = DW'(l); right_in = DW'(r); delay_len = AW'(dl);
    fb_gain = GW'(fb); mix = GW'(mx); mode = md[0]; bypass = bp[0];
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    scramble();
    check("vo_early", valid_out, 1'b0);
    @(negedge clk);
    check("vo", valid_out, 1'b1);
    check("left", left_out, ol);
    check("right", right_out, orr);
    @(negedge clk);
    check("vo_drop", valid_out, 1'b0);
    check("left_hold", left_out, ol);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hl.delete();
    hr.delete();
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check("rst_vo", valid_out, 1'b0);
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse
    frame(16'sh1000, 0, 4, 0, 255, 0, 0);
    check("imp_n0", left_out, 32'sh1000);
    for (int i = 1; i <= 7; i++) begin
      frame(0, 0, 4, 0, 255, 0, 0);
      if (i == 4) check("imp_n4", left_out, 32'sh0FF0);
      else        check("imp_zero", left_out, 0);
    end

    // Feedback
    do_reset();
    frame(16'sh1000, 0, 4, 128, 255, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      frame(0, 0, 4, 128, 255, 0, 0);
      if (i == 4)  check("fb_n4", left_out, 32'sh0FF0);
      if (i == 8)  check("fb_n8", left_out, 32'sh07F8);
      if (i == 12) check("fb_n12", left_out, 32'sh03FC);
    end

    // Ping-pong
    do_reset();
    frame(16'sh1000, 0, 4, 128, 255, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      frame(0, 0, 4, 128, 255, 1, 0);
      if (i == 4)  check("pp_l4", left_out, 32'sh07F8);
      if (i == 8)  check("pp_r8", right_out, 32'sh03FC);
      if (i == 12) check("pp_l12", left_out, 32'sh01FE);
    end

    // Saturation both directions
    do_reset();
    frame(16'sh7000, -32768, 4, 0, 255, 0, 0);
    repeat (3) frame(0, 0, 4, 0, 255, 0, 0);
    frame(16'sh7000, -32768, 4, 0, 255, 0, 0);
    check("sat_pos", left_out, 32'sh7FFF);
    check("sat_neg", right_out, -32768);

    // Wrap and warm-up: ramp through two pointer wraps
    do_reset();
    for (int i = 0; i < 40; i++) begin
      frame(i * 100 - 1000, 1000 - i * 50, 15, 0, 255, 0, 0);
      if (i < 15) check("warm_tap0", left_out, i * 100 - 1000);
    end

    // delay_len 0 behaves as 1
    do_reset();
    frame(16'sh1000, 0, 0, 0, 255, 0, 0);
    frame(0, 0, 0, 0, 255, 0, 0);
    check("dl0_n1", left_out, 32'sh0FF0);

    // Reset mid-stream drops the in-flight frame
    frame(123, -456, 1, 100, 200, 0, 0);
    left_in = 16'sh2000; right_in = 16'sh1000; delay_len = 1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hl.delete(); hr.delete();
    check("mid_rst_vo", valid_out, 1'b0);
    check("mid_rst_left", left_out, 0);
    check("mid_rst_right", right_out, 0);
    @(negedge clk);
    check("mid_rst_drop", valid_out, 1'b0);
    @(negedge clk);
    frame(50, 60, 1, 0, 255, 0, 0);

    // rst dominates a simultaneous valid_in
    rst = 1'b1; valid_in = 1'b1; left_in = 16'sh1234;
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    hl.delete(); hr.delete();
    @(negedge clk);
    check("rst_dom_vo1", valid_out, 1'b0);
    @(negedge clk);
    check("rst_dom_vo2", valid_out, 1'b0);
    check("rst_dom_left", left_out, 0);

    // Random frames: bypass toggles, mode and delay changes
    for (int i = 0; i < 300; i++) begin
      int dl;
      dl = (i % 20 < 15) ? (i / 20) % DEPTH : int'($urandom_range(0, DEPTH - 1));
      frame(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            dl, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
